// File: rtl/vend_dispenser.sv
// Dispense back end: queues vend/change requests and drives the product motor
// and the coin hopper (4-phase eject/ack handshake with timeout).
module vend_dispenser #(
    parameter int FIFO_DEPTH   = 4,
    parameter int MOTOR_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_in,
    input  logic [1:0] change_in,
    input  logic       hopper_ack,
    output logic       motor_on,
    output logic       coin_eject,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       fault,
    output logic [7:0] coins_dispensed
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (MOTOR_CYCLES > ACK_TIMEOUT) ? MOTOR_CYCLES : ACK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] MOTOR_LAST    = TMR_W'(MOTOR_CYCLES - 1);
    localparam logic [TMR_W-1:0] ACK_LAST      = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MOTOR    = 3'd1,
        ST_COIN_REQ = 3'd2,
        ST_COIN_REL = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]       remaining_q, remaining_d;
    logic [7:0]       coins_q, coins_d;
    logic             motor_on_q, coin_eject_q, busy_q, fifo_full_q, overflow_q, fault_q;

    logic       req_valid_s;
    logic       fifo_empty_s;
    logic       fifo_full_s;
    logic       push_s;
    logic       pop_s;
    logic [2:0] head_s;
    logic       timed_s;

    assign req_valid_s  = vend_in | (change_in != 2'd0);
    assign fifo_empty_s = (count_q == CNT_W'(0));
    assign fifo_full_s  = (count_q == FIFO_FULL_CNT);
    assign head_s       = mem_q[rd_ptr_q];
    // A full FIFO still takes a request when the head leaves on the same edge.
    assign push_s       = req_valid_s & (~fifo_full_s | pop_s);
    assign timed_s      = (state_q == ST_MOTOR) | (state_q == ST_COIN_REQ) | (state_q == ST_COIN_REL);

    // Next-state, pop decision and coin bookkeeping.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coins_d     = coins_q;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    remaining_d = head_s[1:0];
                    state_d     = head_s[2] ? ST_MOTOR : ST_COIN_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MOTOR: begin
                if (tmr_q == MOTOR_LAST) begin
                    state_d = (remaining_q != 2'd0) ? ST_COIN_REQ : ST_IDLE;
                end else begin
                    state_d = ST_MOTOR;
                end
            end
            ST_COIN_REQ: begin
                if (hopper_ack) begin
                    remaining_d = remaining_q - 2'd1;
                    coins_d     = coins_q + 8'd1;
                    state_d     = ST_COIN_REL;
                end else if (tmr_q == ACK_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_COIN_REQ;
                end
            end
            ST_COIN_REL: begin
                if (!hopper_ack) begin
                    state_d = (remaining_q != 2'd0) ? ST_COIN_REQ : ST_IDLE;
                end else if (tmr_q == ACK_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    state_d = ST_COIN_REL;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Shared motor/handshake timer: restarts on every state change.
    always_comb begin
        if (timed_s && (state_d == state_q)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end else begin
            tmr_d = '0;
        end
    end

    // FIFO occupancy update.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM, timer, FIFO pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            remaining_q  <= 2'd0;
            coins_q      <= 8'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            motor_on_q   <= 1'b0;
            coin_eject_q <= 1'b0;
            busy_q       <= 1'b0;
            fifo_full_q  <= 1'b0;
            overflow_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            remaining_q  <= remaining_d;
            coins_q      <= coins_d;
            wr_ptr_q     <= push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_q     <= pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            count_q      <= count_d;
            motor_on_q   <= (state_d == ST_MOTOR);
            coin_eject_q <= (state_d == ST_COIN_REQ);
            busy_q       <= (state_d != ST_IDLE) | (count_d != CNT_W'(0));
            fifo_full_q  <= (count_d == FIFO_FULL_CNT);
            overflow_q   <= overflow_q | (req_valid_s & ~push_s);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    // Request storage; entry is {vend, change}.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 3'd0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {vend_in, change_in};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign motor_on        = motor_on_q;
    assign coin_eject      = coin_eject_q;
    assign busy            = busy_q;
    assign fifo_full       = fifo_full_q;
    assign overflow        = overflow_q;
    assign fault           = fault_q;
    assign coins_dispensed = coins_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: hand-computed cycle-exact expectations.
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend_in;
    logic [1:0] change_in;
    logic       hopper_ack;
    logic       motor_on;
    logic       coin_eject;
    logic       busy;
    logic       fifo_full;
    logic       overflow;
    logic       fault;
    logic [7:0] coins_dispensed;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vend_dispenser #(
        .FIFO_DEPTH  (4),
        .MOTOR_CYCLES(8),
        .ACK_TIMEOUT (255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .vend_in        (vend_in),
        .change_in      (change_in),
        .hopper_ack     (hopper_ack),
        .motor_on       (motor_on),
        .coin_eject     (coin_eject),
        .busy           (busy),
        .fifo_full      (fifo_full),
        .overflow       (overflow),
        .fault          (fault),
        .coins_dispensed(coins_dispensed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        vend_in    = 1'b0;
        change_in  = 2'd0;
        hopper_ack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Hopper acks 3 cycles after eject rises, drops ack 2 cycles after release.
    task automatic do_coin(input string tag, input logic [7:0] exp_coins);
        tick();
        chk({tag, "_eject_hold1"}, 32'(coin_eject), 32'd1);
        tick();
        chk({tag, "_eject_hold2"}, 32'(coin_eject), 32'd1);
        hopper_ack = 1'b1;
        tick();
        chk({tag, "_eject_rel"}, 32'(coin_eject), 32'd0);
        chk({tag, "_coins"}, 32'(coins_dispensed), 32'(exp_coins));
        tick();
        chk({tag, "_eject_low"}, 32'(coin_eject), 32'd0);
        hopper_ack = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        rst        = 1'b1;
        vend_in    = 1'b0;
        change_in  = 2'd0;
        hopper_ack = 1'b0;
        tick();
        tick();
        chk("rst_motor", 32'(motor_on), 32'd0);
        chk("rst_eject", 32'(coin_eject), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_coins", 32'(coins_dispensed), 32'd0);
        rst = 1'b0;

        // 1: vend only -> 8 motor cycles, no eject
        vend_in = 1'b1;
        tick();
        vend_in = 1'b0;
        chk("t1_latency_motor", 32'(motor_on), 32'd0);
        chk("t1_busy_queued", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_motor_on", 32'(motor_on), 32'd1);
            chk("t1_no_eject", 32'(coin_eject), 32'd0);
        end
        tick();
        chk("t1_motor_off", 32'(motor_on), 32'd0);
        chk("t1_eject_off", 32'(coin_eject), 32'd0);
        chk("t1_busy_off", 32'(busy), 32'd0);

        // 2: vend + 2 coins
        do_reset();
        vend_in   = 1'b1;
        change_in = 2'd2;
        tick();
        vend_in   = 1'b0;
        change_in = 2'd0;
        chk("t2_latency_motor", 32'(motor_on), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_motor_on", 32'(motor_on), 32'd1);
        end
        tick();
        chk("t2_motor_off", 32'(motor_on), 32'd0);
        chk("t2_eject1_rise", 32'(coin_eject), 32'd1);
        do_coin("t2_c1", 8'd1);
        chk("t2_eject2_rise", 32'(coin_eject), 32'd1);
        do_coin("t2_c2", 8'd2);
        chk("t2_done_eject", 32'(coin_eject), 32'd0);
        chk("t2_done_busy", 32'(busy), 32'd0);
        chk("t2_done_coins", 32'(coins_dispensed), 32'd2);

        // 3: change only -> no motor, one handshake
        do_reset();
        change_in = 2'd1;
        tick();
        change_in = 2'd0;
        chk("t3_latency_eject", 32'(coin_eject), 32'd0);
        tick();
        chk("t3_eject_rise", 32'(coin_eject), 32'd1);
        chk("t3_no_motor", 32'(motor_on), 32'd0);
        do_coin("t3_c1", 8'd1);
        chk("t3_done_busy", 32'(busy), 32'd0);
        chk("t3_done_motor", 32'(motor_on), 32'd0);
        chk("t3_done_coins", 32'(coins_dispensed), 32'd1);

        // 4: six back-to-back vends, sixth dropped
        do_reset();
        vend_in = 1'b1;
        tick();
        chk("t4_e1_full", 32'(fifo_full), 32'd0);
        tick();
        chk("t4_e2_motor", 32'(motor_on), 32'd1);
        tick();
        tick();
        tick();
        chk("t4_e5_full", 32'(fifo_full), 32'd1);
        chk("t4_e5_ovf", 32'(overflow), 32'd0);
        tick();
        vend_in = 1'b0;
        chk("t4_e6_full", 32'(fifo_full), 32'd1);
        chk("t4_e6_ovf", 32'(overflow), 32'd1);
        tick();
        tick();
        tick();
        chk("t4_e9_motor", 32'(motor_on), 32'd1);
        tick();
        chk("t4_e10_idle_motor", 32'(motor_on), 32'd0);
        chk("t4_e10_full", 32'(fifo_full), 32'd1);
        // Push while full, accepted because the head pops on the same edge
        vend_in = 1'b1;
        tick();
        vend_in = 1'b0;
        chk("t4_e11_motor", 32'(motor_on), 32'd1);
        chk("t4_e11_full_kept", 32'(fifo_full), 32'd1);
        chk("t4_e11_ovf_sticky", 32'(overflow), 32'd1);

        // 5: hopper never acks -> fault after 255 cycles of eject
        do_reset();
        change_in = 2'd1;
        tick();
        change_in = 2'd0;
        tick();
        chk("t5_eject_rise", 32'(coin_eject), 32'd1);
        for (int i = 0; i < 254; i++) begin
            tick();
        end
        chk("t5_eject_last", 32'(coin_eject), 32'd1);
        chk("t5_fault_before", 32'(fault), 32'd0);
        tick();
        chk("t5_eject_drop", 32'(coin_eject), 32'd0);
        chk("t5_fault_set", 32'(fault), 32'd1);
        chk("t5_busy_fault", 32'(busy), 32'd1);
        // FAULT keeps accepting pushes but never pops
        vend_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        vend_in = 1'b0;
        chk("t5_fault_full", 32'(fifo_full), 32'd1);
        chk("t5_fault_no_motor", 32'(motor_on), 32'd0);
        chk("t5_fault_ovf", 32'(overflow), 32'd0);
        tick();
        tick();
        chk("t5_fault_sticky", 32'(fault), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_fault", 32'(fault), 32'd0);
        chk("t5_rst_full", 32'(fifo_full), 32'd0);

        // 6: reset mid-motor with two entries queued
        do_reset();
        vend_in = 1'b1;
        tick();
        tick();
        tick();
        vend_in = 1'b0;
        chk("t6_motor_c2", 32'(motor_on), 32'd1);
        tick();
        tick();
        chk("t6_motor_c4", 32'(motor_on), 32'd1);
        chk("t6_busy_c4", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_motor", 32'(motor_on), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_full", 32'(fifo_full), 32'd0);
        chk("t6_rst_coins", 32'(coins_dispensed), 32'd0);
        tick();
        tick();
        chk("t6_queue_flushed", 32'(motor_on), 32'd0);
        chk("t6_queue_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
